// File: rtl/mult8x8_prod_acc_if.sv
// rtl/mult8x8_prod_acc_if.sv - product-in / sum-out handshake bundle for the accumulation stage
//
// Product stream (master -> slave): P[15:0], P_valid, P_last; P_ready returned.
// Result stream (slave -> master): S[ACC_W-1:0], S_cnt[CNT_W-1:0], S_ovf, S_valid;
// S_ready returned.
// master: upstream multiplier plus downstream consumer side. slave: the accumulator.

interface mult8x8_prod_acc_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  logic [15:0]      P;
  logic             P_valid;
  logic             P_last;
  logic             P_ready;
  logic [ACC_W-1:0] S;
  logic [CNT_W-1:0] S_cnt;
  logic             S_ovf;
  logic             S_valid;
  logic             S_ready;

  modport master (
    output P, P_valid, P_last, S_ready,
    input  P_ready, S, S_cnt, S_ovf, S_valid
  );

  modport slave (
    input  P, P_valid, P_last, S_ready,
    output P_ready, S, S_cnt, S_ovf, S_valid
  );
endinterface

// File: rtl/mult8x8_prod_acc.sv
// rtl/mult8x8_prod_acc.sv - dot-product accumulator behind the 8x8 approximate multiplier
//
// Sums a vector of unsigned 16-bit products terminated by P_last and presents
// {S, S_cnt, S_ovf} through a one-entry registered output with valid/ready.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active-high; discards partial sum and pending result
//   bus  - mult8x8_prod_acc_if.slave (product stream in, result stream out)
// Parameters: ACC_W (16..32) accumulator/sum width, CNT_W product-counter width.
// Option: MULT_ACC_SAT_EN defined -> overflowing adds clamp to all-ones;
//         undefined -> adds wrap. Either way overflow sets the sticky flag.

module mult8x8_prod_acc #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mult8x8_prod_acc_if.slave     bus
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic [CNT_W-1:0] s_cnt_q, s_cnt_d;
  logic             s_ovf_q, s_ovf_d;

  logic             p_ready;
  logic             accept;
  logic [ACC_W:0]   sum_ext;
  logic             add_ovf;
  logic [ACC_W-1:0] add_res;
  logic [CNT_W-1:0] cnt_inc;

  // Adder shared by the mid-vector and last-beat paths; the extra top bit is the carry.
  always_comb begin
    sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(bus.P);
    add_ovf = sum_ext[ACC_W];
`ifdef MULT_ACC_SAT_EN
    // Once clamped, any further non-zero add carries out again, so it stays clamped.
    add_res = add_ovf ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    add_res = sum_ext[ACC_W-1:0];
`endif
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Output slot is free when empty or being drained this cycle.
  assign p_ready = (state_q == ST_EMPTY) || bus.S_ready;
  assign accept  = bus.P_valid && p_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    s_d     = s_q;
    s_cnt_d = s_cnt_q;
    s_ovf_d = s_ovf_q;

    if (state_q == ST_FULL && bus.S_ready) begin
      state_d = ST_EMPTY;
    end

    if (accept) begin
      if (bus.P_last) begin
        // Reload overrides the drain above when both happen in one cycle.
        state_d = ST_FULL;
        s_d     = add_res;
        s_cnt_d = cnt_inc;
        s_ovf_d = ovf_q | add_ovf;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end else begin
        acc_d   = add_res;
        cnt_d   = cnt_inc;
        ovf_d   = ovf_q | add_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      s_q     <= '0;
      s_cnt_q <= '0;
      s_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      s_q     <= s_d;
      s_cnt_q <= s_cnt_d;
      s_ovf_q <= s_ovf_d;
    end
  end

  assign bus.P_ready = p_ready;
  assign bus.S       = s_q;
  assign bus.S_cnt   = s_cnt_q;
  assign bus.S_ovf   = s_ovf_q;
  assign bus.S_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_mult8x8_prod_acc.sv
// tb/tb_mult8x8_prod_acc.sv - directed self-checking bench for mult8x8_prod_acc
//
// Three instances: u_main (ACC_W=24, CNT_W=8), u_w16 (ACC_W=16) for overflow,
// u_c2 (CNT_W=2) for counter saturation. Honours MULT_ACC_SAT_EN for expectations.

module tb_mult8x8_prod_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  mult8x8_prod_acc_if #(.ACC_W(24), .CNT_W(8)) b0 ();
  mult8x8_prod_acc_if #(.ACC_W(16), .CNT_W(8)) b16 ();
  mult8x8_prod_acc_if #(.ACC_W(24), .CNT_W(2)) bc ();

  mult8x8_prod_acc #(.ACC_W(24), .CNT_W(8)) u_main (.clk(clk), .rst(rst), .bus(b0));
  mult8x8_prod_acc #(.ACC_W(16), .CNT_W(8)) u_w16  (.clk(clk), .rst(rst), .bus(b16));
  mult8x8_prod_acc #(.ACC_W(24), .CNT_W(2)) u_c2   (.clk(clk), .rst(rst), .bus(bc));

`ifdef MULT_ACC_SAT_EN
  localparam logic [15:0] EXP_W16_S = 16'hFFFF;
`else
  localparam logic [15:0] EXP_W16_S = 16'h0001;
`endif

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total_cnt++; if (b0.P_ready !== 1'b1) $display("FAIL rst_pready_during: got %b exp 1", b0.P_ready); else pass_cnt++;
    total_cnt++; if (b0.S_valid !== 1'b0) $display("FAIL rst_svalid_during: got %b exp 0", b0.S_valid); else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++; if (b0.S !== 24'h0) $display("FAIL rst_s: got %h exp 0", b0.S); else pass_cnt++;
    total_cnt++; if (b0.S_cnt !== 8'h0) $display("FAIL rst_scnt: got %h exp 0", b0.S_cnt); else pass_cnt++;
    total_cnt++; if (b0.S_ovf !== 1'b0) $display("FAIL rst_sovf: got %b exp 0", b0.S_ovf); else pass_cnt++;
    total_cnt++; if (b0.S_valid !== 1'b0) $display("FAIL rst_svalid: got %b exp 0", b0.S_valid); else pass_cnt++;
    total_cnt++; if (b0.P_ready !== 1'b1) $display("FAIL rst_pready: got %b exp 1", b0.P_ready); else pass_cnt++;

    // Partial vector 100,200 then reset: must be discarded.
    b0.S_ready = 1'b1;
    b0.P_valid = 1'b1; b0.P_last = 1'b0; b0.P = 16'd100;
    tick();
    b0.P = 16'd200;
    tick();
    b0.P_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b0.P_valid = 1'b1; b0.P_last = 1'b1; b0.P = 16'd5;
    tick();
    b0.P_valid = 1'b0; b0.P_last = 1'b0;
    total_cnt++; if (b0.S !== 24'd5) $display("FAIL rst_mid_s: got %0d exp 5", b0.S); else pass_cnt++;
    total_cnt++; if (b0.S_cnt !== 8'd1) $display("FAIL rst_mid_scnt: got %0d exp 1", b0.S_cnt); else pass_cnt++;
    total_cnt++; if (b0.S_valid !== 1'b1) $display("FAIL rst_mid_svalid: got %b exp 1", b0.S_valid); else pass_cnt++;
    tick();

    // Pending unconsumed result must be cleared by reset.
    b0.S_ready = 1'b0;
    b0.P_valid = 1'b1; b0.P_last = 1'b1; b0.P = 16'd44;
    tick();
    b0.P_valid = 1'b0; b0.P_last = 1'b0;
    total_cnt++; if (b0.S_valid !== 1'b1) $display("FAIL rst_pend_loaded: got %b exp 1", b0.S_valid); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (b0.S_valid !== 1'b0) $display("FAIL rst_pend_svalid: got %b exp 0", b0.S_valid); else pass_cnt++;
    total_cnt++; if (b0.S !== 24'h0) $display("FAIL rst_pend_s: got %h exp 0", b0.S); else pass_cnt++;
    b0.S_ready = 1'b1;
  endtask

  task automatic test_vector();
    b0.S_ready = 1'b1;
    b0.P_valid = 1'b1; b0.P_last = 1'b0; b0.P = 16'h00FF;
    tick();
    b0.P = 16'h1000;
    tick();
    b0.P = 16'hFFFF; b0.P_last = 1'b1;
    tick();
    b0.P_valid = 1'b0; b0.P_last = 1'b0;
    total_cnt++; if (b0.S !== 24'h0110FE) $display("FAIL vec_s: got %h exp 0110fe", b0.S); else pass_cnt++;
    total_cnt++; if (b0.S_cnt !== 8'd3) $display("FAIL vec_scnt: got %0d exp 3", b0.S_cnt); else pass_cnt++;
    total_cnt++; if (b0.S_ovf !== 1'b0) $display("FAIL vec_sovf: got %b exp 0", b0.S_ovf); else pass_cnt++;
    total_cnt++; if (b0.S_valid !== 1'b1) $display("FAIL vec_svalid: got %b exp 1", b0.S_valid); else pass_cnt++;
    tick();
    total_cnt++; if (b0.S_valid !== 1'b0) $display("FAIL vec_svalid_drop: got %b exp 0", b0.S_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    b0.S_ready = 1'b1;
    b0.P_valid = 1'b1; b0.P_last = 1'b0; b0.P = 16'd10;
    #1;
    total_cnt++; if (b0.P_ready !== 1'b1) $display("FAIL b2b_pready0: got %b exp 1", b0.P_ready); else pass_cnt++;
    tick();
    b0.P = 16'd20; b0.P_last = 1'b1;
    #1;
    total_cnt++; if (b0.P_ready !== 1'b1) $display("FAIL b2b_pready1: got %b exp 1", b0.P_ready); else pass_cnt++;
    tick();
    b0.P = 16'd7; b0.P_last = 1'b1;
    #1;
    total_cnt++; if (b0.S !== 24'd30) $display("FAIL b2b_s0: got %0d exp 30", b0.S); else pass_cnt++;
    total_cnt++; if (b0.S_cnt !== 8'd2) $display("FAIL b2b_scnt0: got %0d exp 2", b0.S_cnt); else pass_cnt++;
    total_cnt++; if (b0.P_ready !== 1'b1) $display("FAIL b2b_pready2: got %b exp 1", b0.P_ready); else pass_cnt++;
    tick();
    b0.P_valid = 1'b0; b0.P_last = 1'b0;
    total_cnt++; if (b0.S !== 24'd7) $display("FAIL b2b_s1: got %0d exp 7", b0.S); else pass_cnt++;
    total_cnt++; if (b0.S_cnt !== 8'd1) $display("FAIL b2b_scnt1: got %0d exp 1", b0.S_cnt); else pass_cnt++;
    total_cnt++; if (b0.S_valid !== 1'b1) $display("FAIL b2b_svalid1: got %b exp 1", b0.S_valid); else pass_cnt++;
    tick();
  endtask

  task automatic test_backpressure();
    b0.S_ready = 1'b0;
    b0.P_valid = 1'b1; b0.P_last = 1'b1; b0.P = 16'd3;
    tick();
    b0.P = 16'd9;
    for (int i = 0; i < 5; i++) begin
      #1;
      total_cnt++; if (b0.P_ready !== 1'b0) $display("FAIL bp_pready[%0d]: got %b exp 0", i, b0.P_ready); else pass_cnt++;
      total_cnt++; if (b0.S !== 24'd3 || b0.S_valid !== 1'b1) $display("FAIL bp_hold[%0d]: got S=%0d V=%b exp S=3 V=1", i, b0.S, b0.S_valid); else pass_cnt++;
      tick();
    end
    b0.S_ready = 1'b1;
    #1;
    total_cnt++; if (b0.P_ready !== 1'b1) $display("FAIL bp_release_pready: got %b exp 1", b0.P_ready); else pass_cnt++;
    tick();
    b0.P_valid = 1'b0; b0.P_last = 1'b0;
    total_cnt++; if (b0.S !== 24'd9) $display("FAIL bp_reload_s: got %0d exp 9", b0.S); else pass_cnt++;
    total_cnt++; if (b0.S_valid !== 1'b1) $display("FAIL bp_reload_svalid: got %b exp 1", b0.S_valid); else pass_cnt++;
    tick();
    total_cnt++; if (b0.S_valid !== 1'b0) $display("FAIL bp_drain_svalid: got %b exp 0", b0.S_valid); else pass_cnt++;
  endtask

  task automatic test_overflow();
    b16.S_ready = 1'b1;
    b16.P_valid = 1'b1; b16.P_last = 1'b0; b16.P = 16'hFFFF;
    tick();
    b16.P = 16'h0002; b16.P_last = 1'b1;
    tick();
    b16.P = 16'h0001; b16.P_last = 1'b1;
    total_cnt++; if (b16.S !== EXP_W16_S) $display("FAIL ovf_s: got %h exp %h", b16.S, EXP_W16_S); else pass_cnt++;
    total_cnt++; if (b16.S_ovf !== 1'b1) $display("FAIL ovf_sovf: got %b exp 1", b16.S_ovf); else pass_cnt++;
    total_cnt++; if (b16.S_cnt !== 8'd2) $display("FAIL ovf_scnt: got %0d exp 2", b16.S_cnt); else pass_cnt++;
    tick();
    b16.P_valid = 1'b0; b16.P_last = 1'b0;
    // Sticky flag must not leak into the next vector.
    total_cnt++; if (b16.S !== 16'h0001) $display("FAIL ovf_next_s: got %h exp 0001", b16.S); else pass_cnt++;
    total_cnt++; if (b16.S_ovf !== 1'b0) $display("FAIL ovf_next_sovf: got %b exp 0", b16.S_ovf); else pass_cnt++;
    tick();
  endtask

  task automatic test_cnt_sat();
    bc.S_ready = 1'b1;
    bc.P_valid = 1'b1; bc.P = 16'd1; bc.P_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bc.P_last = (i == 4);
      tick();
    end
    bc.P_valid = 1'b0; bc.P_last = 1'b0;
    total_cnt++; if (bc.S !== 24'd5) $display("FAIL cnt_sat_s: got %0d exp 5", bc.S); else pass_cnt++;
    total_cnt++; if (bc.S_cnt !== 2'd3) $display("FAIL cnt_sat_scnt: got %0d exp 3", bc.S_cnt); else pass_cnt++;
    total_cnt++; if (bc.S_valid !== 1'b1) $display("FAIL cnt_sat_svalid: got %b exp 1", bc.S_valid); else pass_cnt++;
    tick();
  endtask

  initial begin
    b0.P = '0;  b0.P_valid = 1'b0;  b0.P_last = 1'b0;  b0.S_ready = 1'b0;
    b16.P = '0; b16.P_valid = 1'b0; b16.P_last = 1'b0; b16.S_ready = 1'b0;
    bc.P = '0;  bc.P_valid = 1'b0;  bc.P_last = 1'b0;  bc.S_ready = 1'b0;
    #1;
    test_reset();
    test_vector();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_cnt_sat();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mult8x8_prod_acc.md
# mult8x8_prod_acc

Downstream accumulation stage for the 8x8 approximate multipliers: consumes one 16-bit product per handshake and sums a vector of products (a dot product) terminated by a last flag. It emits the sum, product count and an overflow flag through a one-entry registered output with valid/ready backpressure. It sits directly behind the combinational 8x8 multiplier output `R`. It is the first clocked stage in the approximate-MAC datapath.

## Interface
- `ACC_W`, 24, accumulator and sum width; legal range 16..32.
- `CNT_W`, 8, product-counter width.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous reset, active-high
- `P`  in  16  product from the multiplier `R` output, unsigned
- `P_valid`  in  1  `P`/`P_last` valid
- `P_last`  in  1  final product of the current vector
- `P_ready`  out  1  stage accepts a product this cycle
- `S`  out  ACC_W  vector sum
- `S_cnt`  out  CNT_W  number of products in the vector
- `S_ovf`  out  1  overflow occurred in this vector
- `S_valid`  out  1  output register holds a result
- `S_ready`  in  1  consumer accepts the result

## Operation
- Internal state:
  - running accumulator `acc` (ACC_W bits)
  - counter `cnt` (CNT_W bits)
  - sticky `ovf`
  - output register {`S`, `S_cnt`, `S_ovf`, `S_valid`}
- Output register FSM:
  - EMPTY: `S_valid`=0.
  - FULL: `S_valid`=1.
  - EMPTY→FULL on an accepted last beat.
  - FULL→EMPTY on `S_ready` with no accepted last beat.
  - FULL→FULL (reload) on `S_ready` together with an accepted last beat.
- `P_ready` = !`S_valid` || `S_ready`. This is combinational from `S_ready`; no other path from inputs to outputs.
- Accept = `P_valid` && `P_ready`.
- Accept with `P_last`=0:
  - `acc` ← `acc` + zero-extended `P`
  - `cnt` ← `cnt`+1, saturating at all-ones
  - `ovf` ← `ovf` | overflow of this add
- Accept with `P_last`=1:
  - `S` ← `acc`+`P` (overflow-handled)
  - `S_cnt` ← `cnt`+1 (saturating)
  - `S_ovf` ← `ovf` | overflow of this add
  - `S_valid` ← 1
  - `acc`, `cnt`, `ovf` ← 0
- Single-beat vector (last on first beat): `S`=`P`, `S_cnt`=1.
- Output fields stay stable while `S_valid`=1 and `S_ready`=0.
- No accept: `acc`, `cnt`, `ovf` hold.
- Reset mid-vector: the partial sum is discarded. The output register clears, including a pending unconsumed result.

## Timing
- Reset values: `acc`=0, `cnt`=0, `ovf`=0, `S`=0, `S_cnt`=0, `S_ovf`=0, `S_valid`=0. With `S_valid`=0, `P_ready`=1 during and after reset.
- Latency: result is visible one cycle after the clock edge that accepts the last beat.
- Throughput: one product per cycle. Back-to-back vectors are accepted without bubbles while `S_ready`=1.
- With `S_ready` held 0 and a result pending, `P_ready`=0. Upstream must hold `P`/`P_valid`/`P_last`.
- An upstream that drops `P_valid` while stalled is permitted. Nothing is lost, because no transfer occurred.

## Configuration
- `MULT_ACC_SAT_EN` defined: overflowing adds clamp `acc`/`S` to 2^ACC_W−1. Subsequent adds stay clamped. Overflow sets `ovf`.
- `MULT_ACC_SAT_EN` undefined: adds wrap modulo 2^ACC_W. Overflow still sets the sticky `ovf`.

## Test plan
- Reset, then idle → all outputs 0 and `P_ready`=1. Assert `rst` mid-vector after P=100,200 → the next vector P=5 (last) yields `S`=5, `S_cnt`=1.
- Vector P=0x00FF, 0x1000, 0xFFFF (last), `S_ready`=1 → one cycle later `S`=0x0110FE, `S_cnt`=3, `S_ovf`=0, `S_valid` for one cycle.
- Two back-to-back vectors {10,20 last}{7 last}, `P_valid` continuous, `S_ready`=1 → `S`=30 (`S_cnt`=2), then `S`=7 (`S_cnt`=1) on consecutive cycles; `P_ready` never drops.
- Backpressure: result pending with `S_ready`=0 for 5 cycles while the next last beat waits → `P_ready`=0, `S` stable. Raise `S_ready` → the new result loads in the same cycle the old one is consumed.
- ACC_W=16, vector 0xFFFF, 0x0002 (last) → with `MULT_ACC_SAT_EN`: `S`=0xFFFF, `S_ovf`=1. Without it: `S`=0x0001, `S_ovf`=1.
- CNT_W=2, a vector of 5 products of 1 → `S`=5, `S_cnt`=3 (saturated).
